// File: rtl/multi_seq_pkg.sv
// Shared constants and state encoding for the multi-cycle sequencer and the decoder.
package multi_seq_pkg;

   localparam int unsigned MS_STEP_W      = 5;
   localparam int unsigned MS_REG_W       = 5;
   localparam int unsigned MS_STRIDE_LOG2 = 2;
   localparam int unsigned MS_OFS_W       = 7;
   localparam int unsigned MS_PERF_W      = 16;

   // Extra-step count the decoder emits for PUSHA (8 registers, 7 extra cycles).
   localparam logic [MS_STEP_W-1:0] OP_PUSHA_MULTI = MS_STEP_W'(7);

   typedef enum logic {
      MS_IDLE = 1'b0,
      MS_RUN  = 1'b1
   } ms_state_e;

endpackage

// File: rtl/multi_seq.sv
// Multi-cycle sequencer: holds PC/IR for multi-step instructions, generates per-step
// register index and address offset, gates irq to instruction boundaries.
// Optional stall counter: define MULTI_SEQ_PERF_EN.
module multi_seq
   import multi_seq_pkg::*;
#(
   parameter int unsigned STEP_W      = MS_STEP_W,
   parameter int unsigned REG_W       = MS_REG_W,
   parameter int unsigned STRIDE_LOG2 = MS_STRIDE_LOG2,
   parameter int unsigned OFS_W       = MS_OFS_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic [STEP_W-1:0] multi,
   input  logic [REG_W-1:0]  rc,
   input  logic              irq_in,
   output logic              irq_out,
   output logic              stall,
   output logic [STEP_W-1:0] step,
   output logic              first,
   output logic              last,
   output logic              ra2_ovr,
   output logic [REG_W-1:0]  ra2_addr,
`ifdef MULTI_SEQ_PERF_EN
   output logic [MS_PERF_W-1:0] stall_cycles,
`endif
   output logic [OFS_W-1:0]  addr_ofs
);

   ms_state_e         state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [STEP_W-1:0] count_q, count_d;

   // State register; en=0 freezes everything via the next-state logic.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MS_IDLE;
         step_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         count_q <= count_d;
      end
   end

   // Next-state and per-step control outputs.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      count_d = count_q;
      stall   = 1'b0;
      first   = 1'b0;
      last    = 1'b0;
      ra2_ovr = 1'b0;
      unique case (state_q)
         MS_IDLE: begin
            first = 1'b1;
            if (multi == '0) begin
               last = 1'b1;
            end else begin
               stall   = 1'b1;
               ra2_ovr = 1'b1;
               if (en) begin
                  state_d = MS_RUN;
                  step_d  = STEP_W'(1);
                  count_d = multi;
               end
            end
         end
         MS_RUN: begin
            ra2_ovr = 1'b1;
            if (step_q < count_q) begin
               stall = 1'b1;
               if (en) step_d = step_q + STEP_W'(1);
            end else begin
               last = 1'b1;
               if (en) begin
                  state_d = MS_IDLE;
                  step_d  = '0;
               end
            end
         end
         default: state_d = MS_IDLE;
      endcase
   end

   assign step     = (state_q == MS_RUN) ? step_q : '0;
   assign ra2_addr = rc + REG_W'(step);
   assign addr_ofs = OFS_W'(step) << STRIDE_LOG2;
   assign irq_out  = irq_in & (state_q == MS_IDLE);

`ifdef MULTI_SEQ_PERF_EN
   // Saturating count of enabled stall cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= '0;
      end else if (stall && en && (stall_cycles != {MS_PERF_W{1'b1}})) begin
         stall_cycles <= stall_cycles + MS_PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_multi_seq.sv
// Scoreboard bench for multi_seq: stimulus pushes expected outputs, negedge monitor compares.
module tb_multi_seq;
   import multi_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       en;
   logic [4:0] multi;
   logic [4:0] rc;
   logic       irq_in;
   logic       irq_out, stall, first, last, ra2_ovr;
   logic [4:0] step, ra2_addr;
   logic [6:0] addr_ofs;
`ifdef MULTI_SEQ_PERF_EN
   logic [15:0] stall_cycles;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic       stall;
      logic [4:0] step;
      logic       first;
      logic       last;
      logic       ovr;
      logic [4:0] ra2;
      logic [6:0] ofs;
      logic       irq;
   } exp_t;

   exp_t sb[$];

   multi_seq dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .multi    (multi),
      .rc       (rc),
      .irq_in   (irq_in),
      .irq_out  (irq_out),
      .stall    (stall),
      .step     (step),
      .first    (first),
      .last     (last),
      .ra2_ovr  (ra2_ovr),
      .ra2_addr (ra2_addr),
`ifdef MULTI_SEQ_PERF_EN
      .stall_cycles (stall_cycles),
`endif
      .addr_ofs (addr_ofs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] x);
      checks++;
      if (a !== x) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, a, x);
      end
   endtask

   function automatic exp_t mk(input string tag, input logic st, input int stp,
                               input logic f, input logic l, input logic o,
                               input int ra, input int ofs, input logic iq);
      exp_t x;
      x.tag = tag; x.stall = st; x.step = 5'(stp); x.first = f; x.last = l;
      x.ovr = o; x.ra2 = 5'(ra); x.ofs = 7'(ofs); x.irq = iq;
      return x;
   endfunction

   // Monitor: compare one expectation per falling edge.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.tag, ".stall"},    16'(stall),    16'(e.stall));
         chk({e.tag, ".step"},     16'(step),     16'(e.step));
         chk({e.tag, ".first"},    16'(first),    16'(e.first));
         chk({e.tag, ".last"},     16'(last),     16'(e.last));
         chk({e.tag, ".ra2_ovr"},  16'(ra2_ovr),  16'(e.ovr));
         chk({e.tag, ".ra2_addr"}, 16'(ra2_addr), 16'(e.ra2));
         chk({e.tag, ".addr_ofs"}, 16'(addr_ofs), 16'(e.ofs));
         chk({e.tag, ".irq_out"},  16'(irq_out),  16'(e.irq));
      end
   end

   task automatic cyc(input logic e, input logic [4:0] m, input logic [4:0] r,
                      input logic irq, input exp_t x);
      en = e; multi = m; rc = r; irq_in = irq;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; en = 1'b0; multi = '0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int st3[11] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7};
      int en3[11] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};

      // Reset values with multi=0, rc=5, irq pending.
      reset_n = 1'b0; en = 1'b1; multi = '0; rc = 5'd5; irq_in = 1'b1;
      sb.push_back(mk("reset", 0, 0, 1, 1, 0, 5, 0, 1));
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;

      // PUSHA: eight cycles, then a single-cycle instruction.
      for (int k = 0; k < 8; k++)
         cyc(1'b1, OP_PUSHA_MULTI, 5'd3, 1'b0,
             mk("pusha", k < 7, k, k == 0, k == 7, 1, 3 + k, 4 * k, 0));
      cyc(1'b1, 5'd0, 5'd3, 1'b0, mk("pusha_idle", 0, 0, 1, 1, 0, 3, 0, 0));

      // en dropped for three cycles at step 4.
      for (int k = 0; k < 11; k++)
         cyc(1'(en3[k]), 5'd7, 5'd3, 1'b0,
             mk("enwait", st3[k] < 7, st3[k], st3[k] == 0, st3[k] == 7, 1,
                3 + st3[k], 4 * st3[k], 0));
      cyc(1'b1, 5'd0, 5'd3, 1'b0, mk("enwait_idle", 0, 0, 1, 1, 0, 3, 0, 0));

      // irq raised at step 2 is held off until the next instruction boundary.
      for (int k = 0; k < 8; k++)
         cyc(1'b1, 5'd7, 5'd3, 1'(k >= 2),
             mk("irqrun", k < 7, k, k == 0, k == 7, 1, 3 + k, 4 * k, 0));
      cyc(1'b1, 5'd0, 5'd3, 1'b1, mk("irq_idle", 0, 0, 1, 1, 0, 3, 0, 1));

      // Asynchronous reset mid-RUN at step 5; checked before any clock edge.
      for (int k = 0; k < 5; k++)
         cyc(1'b1, 5'd7, 5'd3, 1'b0,
             mk("prerst", 1, k, k == 0, 0, 1, 3 + k, 4 * k, 0));
      en = 1'b0; multi = 5'd7; rc = 5'd3; irq_in = 1'b0;
      #1 reset_n = 1'b0;
      #1 sb.push_back(mk("async_rst", 1, 0, 1, 0, 1, 3, 0, 0));
      #5 reset_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
         cyc(1'b1, 5'd2, 5'd3, 1'b0,
             mk("post_rst", k < 2, k, k == 0, k == 2, 1, 3 + k, 4 * k, 0));
      cyc(1'b1, 5'd0, 5'd3, 1'b0, mk("post_idle", 0, 0, 1, 1, 0, 3, 0, 0));

      // ra2_addr wraps modulo 32.
      do_reset();
      for (int k = 0; k < 4; k++)
         cyc(1'b1, 5'd3, 5'd30, 1'b0,
             mk("wrap", k < 3, k, k == 0, k == 3, 1, 30 + k, 4 * k, 0));
      cyc(1'b1, 5'd0, 5'd30, 1'b0, mk("wrap_idle", 0, 0, 1, 1, 0, 30, 0, 0));

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk("sb_drain", 16'(sb.size()), 16'd0);
`ifdef MULTI_SEQ_PERF_EN
      chk("stall_cycles", stall_cycles, 16'd3);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
